div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 155 +++++++++++++++
 tb/tb_div.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Signed 32-bit restoring divider, MIPS DIV semantics.
// One shift-subtract step per cycle; hi = remainder, lo = quotient.
module div (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        divControl,
  output logic        divStop,
  output logic        divZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] dvs_q, dvs_d;
  logic        sa_q, sa_d;
  logic        sq_q, sq_d;
  logic        zero_q, zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        stop_q, stop_d;
  logic        zf_q, zf_d;

  logic [33:0] trial;
  logic [32:0] diff;
  logic        ge;
  logic [32:0] mag_a;
  logic [32:0] mag_b;

  function automatic logic [32:0] mag33(input logic [31:0] x);
    logic [32:0] s;
    s = {x[31], x};
    return x[31] ? (33'd0 - s) : s;
  endfunction

  assign mag_a = mag33(a);
  assign mag_b = mag33(b);

  // Partial remainder never reaches 2*|b|, so diff fits in 33 bits.
  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial[32:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stop_d  = 1'b0;
    zf_d    = 1'b0;
    if (divControl) begin
      rem_d  = {32'd0, mag_a[32]};
      quo_d  = mag_a[31:0];
      dvs_d  = mag_b;
      sa_d   = a[31];
      sq_d   = a[31] ^ b[31];
      if (b == 32'd0) begin
        state_d = DONE;
        zero_d  = 1'b1;
        cnt_d   = 6'd0;
      end else begin
        state_d = RUN;
        zero_d  = 1'b0;
        cnt_d   = 6'd32;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          rem_d = ge ? diff : trial[32:0];
          quo_d = {quo_q[30:0], ge};
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = DONE;
        end
        DONE: begin
          stop_d = 1'b1;
          zf_d   = zero_q;
          if (!zero_q) begin
            lo_d = sq_q ? (32'd0 - quo_q) : quo_q;
            hi_d = sa_q ? (32'd0 - rem_q[31:0])
                        : rem_q[31:0];
          end
          state_d = IDLE;
          cnt_d   = 6'd0;
          rem_d   = 33'd0;
          quo_d   = 32'd0;
          dvs_d   = 33'd0;
          sa_d    = 1'b0;
          sq_d    = 1'b0;
          zero_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          rem_d   = 33'd0;
          quo_d   = 32'd0;
          dvs_d   = 33'd0;
          sa_d    = 1'b0;
          sq_d    = 1'b0;
          zero_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 33'd0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      stop_q  <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sq_q    <= sq_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stop_q  <= stop_d;
      zf_q    <= zf_d;
    end
  end

  assign divStop = stop_q;
  assign divZero = zf_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random
// operands against a plain-arithmetic signed division model.
module tb_div;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        divControl = 1'b0;
  logic        divStop;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  div dut (
    .clk        (clk),
    .Reset      (Reset),
    .a          (a),
    .b          (b),
    .divControl (divControl),
    .divStop    (divStop),
    .divZero    (divZero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] q, output logic [31:0] r);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = 32'(sx / sy);
    r = 32'(sx % sy);
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb);
    a = ta;
    b = tb;
    divControl = 1'b1;
    step();
    divControl = 1'b0;
    a = $urandom;
    b = $urandom;
    n_chk++;
    if ({divStop, divZero} !== 2'b00)
      $display("FAIL start_edge stop/zero got %b%b want 00",
               divStop, divZero);
    else n_pass++;
  endtask

  task automatic expect_done(input logic [31:0] ta, input logic [31:0] tb,
                             input string name);
    logic [31:0] eq;
    logic [31:0] er;
    logic        z;
    int          lat;
    z = (tb == 32'd0);
    lat = z ? 1 : 33;
    if (z) begin
      eq = m_lo;
      er = m_hi;
    end else model(ta, tb, eq, er);
    for (int c = 1; c <= lat; c++) begin
      step();
      n_chk++;
      if ({divStop, divZero} !== {c == lat, z && c == lat})
        $display("FAIL %s c%0d stop/zero got %b%b want %b%b",
                 name, c, divStop, divZero, c == lat, z && c == lat);
      else n_pass++;
      if (c == lat) begin
        m_lo = eq;
        m_hi = er;
      end
      n_chk++;
      if (hi !== m_hi || lo !== m_lo)
        $display("FAIL %s c%0d hi/lo got %h/%h want %h/%h",
                 name, c, hi, lo, m_hi, m_lo);
      else n_pass++;
    end
  endtask

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb,
                         input string name);
    start_op(ta, tb);
    expect_done(ta, tb, name);
  endtask

  task automatic test_reset;
    #1 Reset = 1'b0;
    #1;
    n_chk++;
    if ({divStop, divZero, hi, lo} !== 66'd0)
      $display("FAIL reset_async got %b %b %h %h want 0 0 0 0",
               divStop, divZero, hi, lo);
    else n_pass++;
    divControl = 1'b1;
    a = 32'd100;
    b = 32'd7;
    step();
    n_chk++;
    if ({divStop, divZero, hi, lo} !== 66'd0)
      $display("FAIL reset_hold got %b %b %h %h want 0 0 0 0",
               divStop, divZero, hi, lo);
    else n_pass++;
    divControl = 1'b0;
    #5 Reset = 1'b1;
  endtask

  task automatic test_basic;
    run_div(32'd100, 32'd7, "first_after_reset");
    n_chk++;
    if (lo !== 32'd14 || hi !== 32'd2)
      $display("FAIL pos_pos got %h/%h want 2/14", hi, lo);
    else n_pass++;
    run_div(32'hFFFFFF9C, 32'd7, "neg_pos");
    n_chk++;
    if (lo !== 32'hFFFFFFF2 || hi !== 32'hFFFFFFFE)
      $display("FAIL neg_pos got %h/%h want fffffffe/fffffff2", hi, lo);
    else n_pass++;
    run_div(32'd100, 32'hFFFFFFF9, "pos_neg");
    n_chk++;
    if (lo !== 32'hFFFFFFF2 || hi !== 32'd2)
      $display("FAIL pos_neg got %h/%h want 2/fffffff2", hi, lo);
    else n_pass++;
    run_div(32'd100, 32'd7, "pos_pos");
  endtask

  task automatic test_zero;
    run_div(32'd5, 32'd0, "div_zero");
    n_chk++;
    if (lo !== 32'd14 || hi !== 32'd2)
      $display("FAIL div_zero_keep got %h/%h want 2/14", hi, lo);
    else n_pass++;
    step();
    n_chk++;
    if ({divStop, divZero} !== 2'b00)
      $display("FAIL div_zero_drop got %b%b want 00", divStop, divZero);
    else n_pass++;
  endtask

  task automatic test_overflow;
    run_div(32'h80000000, 32'hFFFFFFFF, "overflow");
    n_chk++;
    if (lo !== 32'h80000000 || hi !== 32'd0)
      $display("FAIL overflow got %h/%h want 0/80000000", hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    start_op(32'd100, 32'd7);
    for (int i = 1; i <= 9; i++) step();
    @(posedge clk);
    #2 Reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    n_chk++;
    if ({divStop, divZero, hi, lo} !== 66'd0)
      $display("FAIL reset_mid got %b %b %h %h want 0 0 0 0",
               divStop, divZero, hi, lo);
    else n_pass++;
    @(posedge clk);
    #3 Reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      n_chk++;
      if (divStop !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
        $display("FAIL reset_mid_quiet c%0d got %b %h %h want 0 0 0",
                 i, divStop, hi, lo);
      else n_pass++;
    end
    run_div(32'd9, 32'd2, "after_reset");
    n_chk++;
    if (lo !== 32'd4 || hi !== 32'd1)
      $display("FAIL after_reset got %h/%h want 1/4", hi, lo);
    else n_pass++;
  endtask

  task automatic test_restart;
    start_op(32'd100, 32'd7);
    for (int i = 1; i <= 4; i++) begin
      step();
      n_chk++;
      if (divStop !== 1'b0)
        $display("FAIL restart_run c%0d stop got %b want 0", i, divStop);
      else n_pass++;
    end
    run_div(32'd9, 32'd2, "restart");
    n_chk++;
    if (lo !== 32'd4 || hi !== 32'd1)
      $display("FAIL restart got %h/%h want 1/4", hi, lo);
    else n_pass++;
  endtask

  task automatic test_abort_done;
    start_op(32'd100, 32'd7);
    for (int i = 1; i <= 32; i++) begin
      step();
      n_chk++;
      if (divStop !== 1'b0)
        $display("FAIL abort_run c%0d stop got %b want 0", i, divStop);
      else n_pass++;
    end
    run_div(32'd20, 32'hFFFFFFFD, "abort_in_done");
  endtask

  task automatic test_back_to_back;
    run_div(32'h7FFFFFFF, 32'd1, "b2b_max");
    run_div(32'h80000000, 32'd1, "b2b_min");
    run_div(32'd0, 32'hFFFFFFFF, "b2b_zero_dvd");
    run_div(32'd3, 32'h80000000, "b2b_min_dvs");
  endtask

  task automatic test_random;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 5);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end else if (sel == 2) begin
        rb = 32'($urandom_range(1, 15));
        if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
      end else if (sel == 3) ra = 32'($urandom_range(0, 20));
      run_div(ra, rb, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_restart();
    test_abort_done();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
